// File: rtl/util_pkg.sv
// -----------------------------------------------------------------------------
// util_pkg
//   Shared helpers for the datapath blocks of this codebase.
//   beat_w(ratio): width of a beat index that counts 0..ratio-1. It is never
//   narrower than one bit, so a ratio of 1 still gets a legal (constant-zero)
//   counter.
// -----------------------------------------------------------------------------
package util_pkg;

  function automatic int beat_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// fifo_rd_serializer
//   Drain side of a sync_fifo_data instance. Pops IN_WIDTH-bit words from the
//   FIFO read port and sends each one as RATIO beats of OUT_WIDTH bits on a
//   valid/ready stream, least-significant slice first. A new word is popped
//   on the same edge that accepts the last beat of the current one, so the
//   stream sustains one beat per cycle with no bubble between words.
//
// Ports
//   clock         in   1          rising-edge clock
//   rstn          in   1          asynchronous reset, active-low
//   fifo_empty    in   1          FIFO empty flag
//   fifo_rd_data  in   IN_WIDTH   FIFO head word (valid when !fifo_empty)
//   fifo_rd_en    out  1          pop request; FIFO head advances this edge
//   flush         in   1          synchronous drop of the buffered word
//   out_valid     out  1          beat valid
//   out_ready     in   1          downstream accepts the beat
//   out_data      out  OUT_WIDTH  current beat
//   out_last      out  1          final beat of the current word
//   busy          out  1          a word is buffered
//   word_cnt      out  CNT_W      words fully sent, wraps
// -----------------------------------------------------------------------------
module fifo_rd_serializer
  import util_pkg::*;
#(
  parameter int  IN_WIDTH  = 32,
  parameter int  RATIO     = 4,
  parameter int  CNT_W     = 16,
  localparam int OUT_WIDTH = IN_WIDTH / RATIO
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int                BEAT_W    = beat_w(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  if ((RATIO < 1) || ((IN_WIDTH % RATIO) != 0)) begin : g_bad_ratio
    $error("fifo_rd_serializer: IN_WIDTH must be a multiple of RATIO (RATIO >= 1)");
  end

  logic [IN_WIDTH-1:0] r_buf;
  logic                r_buf_vld;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_run;
  logic [CNT_W-1:0]    r_word_cnt;

  logic w_on_last;
  logic w_hs;
  logic w_last_hs;

  // flush hides the buffered word from the stream, which also suppresses
  // any handshake in that cycle.
  assign out_valid = r_buf_vld & ~flush;
  assign w_on_last = (r_beat == LAST_BEAT);
  assign out_last  = out_valid & w_on_last;
  assign w_hs      = out_valid & out_ready;
  assign w_last_hs = w_hs & w_on_last;
  assign busy      = r_buf_vld;
  assign word_cnt  = r_word_cnt;

  // Refill either into an empty buffer or on the last handshake of the
  // current word (the back-to-back case). r_run keeps the pop off until one
  // clock after reset release, giving the FIFO time to come out of reset.
  assign fifo_rd_en = r_run & ~fifo_empty & ~flush & (~r_buf_vld | w_last_hs);

  if (RATIO == 1) begin : g_single
    assign out_data = r_buf;
  end else begin : g_slices
    logic [RATIO-1:0][OUT_WIDTH-1:0] w_slices;
    assign w_slices = r_buf;
    assign out_data = w_slices[r_beat];
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch below sees the pre-edge values of r_buf_vld/r_beat regardless of
  // statement order. The data buffer is reset too, because out_data must read
  // zero during and after reset rather than stale or unknown data.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_buf      <= '0;
      r_buf_vld  <= 1'b0;
      r_beat     <= '0;
      r_run      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_run <= 1'b1;

      if (flush) begin
        r_buf_vld <= 1'b0;
        r_beat    <= '0;
      end else if (fifo_rd_en) begin
        r_buf     <= fifo_rd_data;
        r_buf_vld <= 1'b1;
        r_beat    <= '0;
      end else if (w_last_hs) begin
        r_buf_vld <= 1'b0;
        r_beat    <= '0;
      end else if (w_hs) begin
        r_beat <= r_beat + BEAT_W'(1);
      end

      // Counts completed words only; a flushed partial word is not counted
      // and flush never clears the count.
      if (w_last_hs) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_serializer
//   Two instances of fifo_rd_serializer, each fed by a small 16-deep FIFO
//   model: inst A (32-bit words, 4 beats, 16-bit counter) and inst B (32-bit
//   words, 1 beat, 4-bit counter so the counter wraps after 16 words).
//   Expected beats are queued when words are written to a FIFO and checked
//   when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_fifo_rd_serializer;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clock = 1'b0;
  logic rstn;
  logic flush;

  always #5 clock = ~clock;

  // Instance A signals
  logic        a_empty, a_rd_en, a_valid, a_ready, a_last, a_busy;
  logic [31:0] a_rd_data;
  logic [7:0]  a_data;
  logic [15:0] a_cnt;

  // Instance B signals
  logic        b_empty, b_rd_en, b_valid, b_ready, b_last, b_busy;
  logic [31:0] b_rd_data;
  logic [31:0] b_data;
  logic [3:0]  b_cnt;

  fifo_rd_serializer #(.IN_WIDTH(32), .RATIO(4), .CNT_W(16)) u_dut_a (
    .clock        (clock),
    .rstn         (rstn),
    .fifo_empty   (a_empty),
    .fifo_rd_data (a_rd_data),
    .fifo_rd_en   (a_rd_en),
    .flush        (flush),
    .out_valid    (a_valid),
    .out_ready    (a_ready),
    .out_data     (a_data),
    .out_last     (a_last),
    .busy         (a_busy),
    .word_cnt     (a_cnt)
  );

  fifo_rd_serializer #(.IN_WIDTH(32), .RATIO(1), .CNT_W(4)) u_dut_b (
    .clock        (clock),
    .rstn         (rstn),
    .fifo_empty   (b_empty),
    .fifo_rd_data (b_rd_data),
    .fifo_rd_en   (b_rd_en),
    .flush        (flush),
    .out_valid    (b_valid),
    .out_ready    (b_ready),
    .out_data     (b_data),
    .out_last     (b_last),
    .busy         (b_busy),
    .word_cnt     (b_cnt)
  );

  // FIFO models: write side driven by the stimulus, read side by the DUT.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [4:0]  wp_a, rp_a, wp_b, rp_b;

  assign a_empty   = (wp_a == rp_a);
  assign a_rd_data = mem_a[rp_a[3:0]];
  assign b_empty   = (wp_b == rp_b);
  assign b_rd_data = mem_b[rp_b[3:0]];

  always @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rp_a <= '0;
      rp_b <= '0;
    end else begin
      if (a_rd_en) rp_a <= rp_a + 5'd1;
      if (b_rd_en) rp_b <= rp_b + 5'd1;
    end
  end

  // Scoreboard
  beat_t       exp_a[$];
  beat_t       exp_b[$];
  logic [15:0] exp_cnt_a;
  logic [3:0]  exp_cnt_b;
  int          hs_a, hs_b;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] word);
    mem_a[wp_a[3:0]] = word;
    wp_a = wp_a + 5'd1;
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back('{data: {24'd0, word[i*8 +: 8]}, last: (i == 3)});
    end
  endtask

  task automatic push_b(input logic [31:0] word);
    mem_b[wp_b[3:0]] = word;
    wp_b = wp_b + 5'd1;
    exp_b.push_back('{data: word, last: 1'b1});
  endtask

  // Checks the counters, then any beat that will be accepted at the coming edge.
  task automatic monitor();
    beat_t e;
    check("a_word_cnt", a_cnt, exp_cnt_a);
    check("b_word_cnt", b_cnt, exp_cnt_b);
    if (a_valid && a_ready) begin
      hs_a++;
      if (exp_a.size() == 0) begin
        check("a_unexpected_beat", a_valid, 1'b0);
      end else begin
        e = exp_a.pop_front();
        check("a_data", a_data, e.data);
        check("a_last", a_last, e.last);
        if (e.last) exp_cnt_a = exp_cnt_a + 16'd1;
      end
    end
    if (b_valid && b_ready) begin
      hs_b++;
      if (exp_b.size() == 0) begin
        check("b_unexpected_beat", b_valid, 1'b0);
      end else begin
        e = exp_b.pop_front();
        check("b_data", b_data, e.data);
        check("b_last", b_last, e.last);
        if (e.last) exp_cnt_b = exp_cnt_b + 4'd1;
      end
    end
  endtask

  // Inputs are driven just after a falling edge; outputs are sampled 1 time
  // unit later, well before the rising edge.
  task automatic cycle();
    #1;
    monitor();
    @(negedge clock);
  endtask

  initial begin
    int rd_cnt, rd_on_last, first_c, last_c;

    rstn = 1'b0; flush = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    wp_a = '0; wp_b = '0;
    exp_cnt_a = '0; exp_cnt_b = '0; hs_a = 0; hs_b = 0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_last",  a_last,  1'b0);
    check("rst_a_data",  a_data,  8'h00);
    check("rst_a_busy",  a_busy,  1'b0);
    check("rst_a_cnt",   a_cnt,   16'h0);
    check("rst_a_rd_en", a_rd_en, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_b_data",  b_data,  32'h0);
    @(negedge clock);
    rstn = 1'b1;
    repeat (2) cycle();

    // 1: single word, four beats LSB first
    a_ready = 1'b1;
    push_a(32'hDDCC_BBAA);
    #1;
    check("t1_rd_en_same_cycle", a_rd_en, 1'b1);
    check("t1_valid_before_pop", a_valid, 1'b0);
    cycle();
    #1;
    check("t1_valid_after_pop", a_valid, 1'b1);
    hs_a = 0;
    repeat (4) cycle();
    check("t1_beats", hs_a, 4);
    check("t1_cnt", a_cnt, 16'd1);
    check("t1_idle", a_busy, 1'b0);

    // 2: three words back-to-back, no gaps
    push_a(32'h1312_1110);
    push_a(32'h2322_2120);
    push_a(32'h3332_3130);
    hs_a = 0; rd_cnt = 0; rd_on_last = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (a_rd_en) begin
        rd_cnt++;
        if (a_last && a_ready) rd_on_last++;
      end
      if (a_valid && a_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      cycle();
    end
    check("t2_beats", hs_a, 12);
    check("t2_no_gap", last_c - first_c + 1, 12);
    check("t2_pops", rd_cnt, 3);
    check("t2_pops_on_last", rd_on_last, 2);
    check("t2_fifo_empty", a_empty, 1'b1);
    check("t2_cnt", a_cnt, 16'd4);

    // 3: stall mid-word, ready pattern 1,0,0,1
    push_a(32'h4D4C_4B4A);
    cycle();
    cycle();
    a_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t3_stall_valid", a_valid, 1'b1);
      check("t3_stall_data", a_data, exp_a[0].data);
      check("t3_stall_last", a_last, exp_a[0].last);
      cycle();
    end
    a_ready = 1'b1;
    hs_a = 0;
    repeat (3) cycle();
    check("t3_rest_beats", hs_a, 3);
    check("t3_queue_drained", exp_a.size(), 0);
    check("t3_cnt", a_cnt, 16'd5);

    // 4: flush on beat 2 with a second word queued
    push_a(32'h4433_2211);
    push_a(32'h8877_6655);
    cycle();
    cycle();
    cycle();
    flush = 1'b1;
    #1;
    check("t4_flush_valid", a_valid, 1'b0);
    check("t4_flush_no_pop", a_rd_en, 1'b0);
    check("t4_flush_last", a_last, 1'b0);
    void'(exp_a.pop_front());
    void'(exp_a.pop_front());
    cycle();
    flush = 1'b0;
    #1;
    check("t4_after_valid", a_valid, 1'b0);
    check("t4_after_pop", a_rd_en, 1'b1);
    check("t4_after_busy", a_busy, 1'b0);
    cycle();
    repeat (4) cycle();
    check("t4_queue_drained", exp_a.size(), 0);
    check("t4_cnt", a_cnt, 16'd6);
    check("t4_fifo_empty", a_empty, 1'b1);

    // 5: RATIO=1 instance, 16 words fill the FIFO, counter wraps at 16
    for (int i = 0; i < 16; i++) push_b(32'hB000_0000 + i);
    b_ready = 1'b1;
    #1;
    check("t5_fifo_full", wp_b - rp_b, 5'd16);
    check("t5_first_pop", b_rd_en, 1'b1);
    hs_b = 0;
    repeat (19) cycle();
    check("t5_beats", hs_b, 16);
    check("t5_fifo_empty", b_empty, 1'b1);
    check("t5_cnt_wrapped", b_cnt, 4'd0);
    check("t5_idle", b_busy, 1'b0);

    // 6: asynchronous reset in the middle of a word
    push_a(32'hA5A4_A3A2);
    cycle();
    cycle();
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", a_valid, 1'b0);
    check("t6_rst_data",  a_data,  8'h00);
    check("t6_rst_last",  a_last,  1'b0);
    check("t6_rst_busy",  a_busy,  1'b0);
    check("t6_rst_cnt",   a_cnt,   16'h0);
    check("t6_rst_rd_en", a_rd_en, 1'b0);
    exp_a.delete();
    exp_b.delete();
    exp_cnt_a = '0;
    exp_cnt_b = '0;
    wp_a = '0;
    wp_b = '0;
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;
    push_a(32'h5D5C_5B5A);
    #1;
    check("t6_no_pop_at_release", a_rd_en, 1'b0);
    cycle();
    #1;
    check("t6_pop_after_one_clock", a_rd_en, 1'b1);
    cycle();
    repeat (4) cycle();
    check("t6_queue_drained", exp_a.size(), 0);
    check("t6_cnt", a_cnt, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
